// File: rtl/execute_pkg.sv
// Shared types for the execute stage: ALU opcodes, forwarding selects,
// multiplier FSM states and the EX/MEM control bundle.
package execute_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100,
        ALU_MOV = 3'b101,
        ALU_LSL = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_MEM     = 2'b01,
        FWD_WB      = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic rwrite;
        logic we;
        logic data_input_on;
        logic data_input_s;
        logic select_mem;
    } ex_ctrl_t;

    // Counter value of the BUSY cycle that retires the multiply
    localparam logic [1:0] MUL_LAST_CNT = 2'd2;

    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] reg_val,
                                            input logic [31:0] mem_val,
                                            input logic [31:0] wb_val);
        case (fwd_sel_e'(sel))
            FWD_MEM: fwd_mux = mem_val;
            FWD_WB:  fwd_mux = wb_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

endpackage

// File: rtl/execute_alu.sv
// Single-cycle ALU for ADD..LSL with NZCV generation; MUL is handled by the
// iterative multiplier in execute_stage.
module execute_alu
    import execute_pkg::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [2:0]  alu_signal,
    input  logic [3:0]  flags_in,
    output logic [31:0] result,
    output logic [3:0]  flags_out
);

    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic        c_s;
    logic        v_s;

    assign sum_s  = {1'b0, op_a} + {1'b0, op_b};
    // Subtract as A + ~B + 1 so bit 32 is directly the NOT-borrow carry
    assign diff_s = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;

    // Operation select; carry and overflow only change for ADD/SUB
    always_comb begin
        result = 32'd0;
        c_s    = flags_in[1];
        v_s    = flags_in[0];
        case (alu_op_e'(alu_signal))
            ALU_ADD: begin
                result = sum_s[31:0];
                c_s    = sum_s[32];
                v_s    = (op_a[31] == op_b[31]) && (sum_s[31] != op_a[31]);
            end
            ALU_SUB: begin
                result = diff_s[31:0];
                c_s    = diff_s[32];
                v_s    = (op_a[31] != op_b[31]) && (diff_s[31] != op_a[31]);
            end
            ALU_AND: result = op_a & op_b;
            ALU_ORR: result = op_a | op_b;
            ALU_EOR: result = op_a ^ op_b;
            ALU_MOV: result = op_b;
            ALU_LSL: result = op_a << op_b[4:0];
            default: result = 32'd0;
        endcase
        flags_out = {result[31], (result == 32'd0), c_s, v_s};
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, 4-cycle byte-serial multiplier,
// NZCV flags and the EX/MEM pipeline register.
module execute_stage
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] imm_extend,
    input  logic [31:0] inst,
    input  logic [3:0]  rd,
    input  logic        rwrite,
    input  logic        we,
    input  logic        data_input_on,
    input  logic        data_input_s,
    input  logic        opb_select,
    input  logic        select_mem,
    input  logic [2:0]  alu_signal,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic [31:0] mem_fwd_data,
    input  logic [31:0] wb_fwd_data,
    output logic [31:0] alu_result_q,
    output logic [31:0] store_data_q,
    output logic [3:0]  rd_q,
    output logic        rwrite_q,
    output logic        we_q,
    output logic        data_input_on_q,
    output logic        data_input_s_q,
    output logic        select_mem_q,
    output logic [3:0]  nzcv_q,
    output logic        stall_req
);

    logic [31:0] op_a_s, fb_s, op_b_s, alu_res_s;
    logic [3:0]  alu_flags_s;
    logic        is_mul_s;
    ex_ctrl_t    ctrl_in_s;

    ex_state_e   state_r, state_n;
    logic [1:0]  cnt_r, cnt_n, k_s;
    logic [31:0] acc_r, acc_n, a_r, a_n, fb_r, fb_n, pp_s, mul_res_s;
    logic [23:0] hi_b_r, hi_b_n;
    logic [7:0]  byte_s;
    logic [3:0]  rd_r, rd_n;
    logic        s_r, s_n;
    ex_ctrl_t    ctrl_r, ctrl_n;

    logic [31:0] res_out_r, res_out_n, store_out_r, store_out_n;
    logic [3:0]  rd_out_r, rd_out_n, nzcv_r, nzcv_n;
    ex_ctrl_t    ctrl_out_r, ctrl_out_n;

    // Only the S bit of the instruction word matters here
    logic        unused_inst_s;
    assign unused_inst_s = ^{inst[31:21], inst[19:0]};

    assign op_a_s    = fwd_mux(fwd_a_sel, data1, mem_fwd_data, wb_fwd_data);
    assign fb_s      = fwd_mux(fwd_b_sel, data2, mem_fwd_data, wb_fwd_data);
    assign op_b_s    = opb_select ? imm_extend : fb_s;
    assign is_mul_s  = (alu_op_e'(alu_signal) == ALU_MUL);
    assign ctrl_in_s = {rwrite, we, data_input_on, data_input_s, select_mem};

    execute_alu u_alu (
        .op_a       (op_a_s),
        .op_b       (op_b_s),
        .alu_signal (alu_signal),
        .flags_in   (nzcv_r),
        .result     (alu_res_s),
        .flags_out  (alu_flags_s)
    );

    // BUSY cycle with count c accumulates byte k = c+1 of the latched B
    assign k_s = cnt_r + 2'd1;

    // Byte of the latched multiplier operand for the current iteration
    always_comb begin
        case (k_s)
            2'd1:    byte_s = hi_b_r[7:0];
            2'd2:    byte_s = hi_b_r[15:8];
            default: byte_s = hi_b_r[23:16];
        endcase
    end

    assign pp_s      = (a_r * {24'd0, byte_s}) << {k_s, 3'b000};
    assign mul_res_s = acc_r + pp_s;

    assign stall_req = !reset && !flush &&
                       (((state_r == IDLE) && is_mul_s) ||
                        ((state_r == BUSY) && (cnt_r < MUL_LAST_CNT)));

    // Next-state, multiplier datapath and EX/MEM register inputs
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        acc_n       = acc_r;
        a_n         = a_r;
        hi_b_n      = hi_b_r;
        fb_n        = fb_r;
        rd_n        = rd_r;
        s_n         = s_r;
        ctrl_n      = ctrl_r;
        res_out_n   = res_out_r;
        store_out_n = store_out_r;
        rd_out_n    = rd_out_r;
        ctrl_out_n  = ctrl_out_r;
        nzcv_n      = nzcv_r;
        if (flush) begin
            ctrl_out_n = '0;
            state_n    = IDLE;
            cnt_n      = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (is_mul_s) begin
                        a_n        = op_a_s;
                        hi_b_n     = op_b_s[31:8];
                        acc_n      = op_a_s * {24'd0, op_b_s[7:0]};
                        fb_n       = fb_s;
                        rd_n       = rd;
                        s_n        = inst[20];
                        ctrl_n     = ctrl_in_s;
                        cnt_n      = 2'd0;
                        state_n    = BUSY;
                        ctrl_out_n = '0;
                    end else begin
                        res_out_n   = alu_res_s;
                        store_out_n = fb_s;
                        rd_out_n    = rd;
                        ctrl_out_n  = ctrl_in_s;
                        if (inst[20]) begin
                            nzcv_n = alu_flags_s;
                        end else begin
                            nzcv_n = nzcv_r;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r < MUL_LAST_CNT) begin
                        acc_n      = mul_res_s;
                        cnt_n      = cnt_r + 2'd1;
                        ctrl_out_n = '0;
                    end else begin
                        res_out_n   = mul_res_s;
                        store_out_n = fb_r;
                        rd_out_n    = rd_r;
                        ctrl_out_n  = ctrl_r;
                        cnt_n       = 2'd0;
                        state_n     = IDLE;
                        if (s_r) begin
                            nzcv_n = {mul_res_s[31], (mul_res_s == 32'd0), nzcv_r[1:0]};
                        end else begin
                            nzcv_n = nzcv_r;
                        end
                    end
                end
                default: begin
                    state_n    = IDLE;
                    cnt_n      = 2'd0;
                    ctrl_out_n = '0;
                end
            endcase
        end
    end

    // State, multiplier and EX/MEM registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            acc_r       <= 32'd0;
            a_r         <= 32'd0;
            hi_b_r      <= 24'd0;
            fb_r        <= 32'd0;
            rd_r        <= 4'd0;
            s_r         <= 1'b0;
            ctrl_r      <= '0;
            res_out_r   <= 32'd0;
            store_out_r <= 32'd0;
            rd_out_r    <= 4'd0;
            ctrl_out_r  <= '0;
            nzcv_r      <= 4'd0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            acc_r       <= acc_n;
            a_r         <= a_n;
            hi_b_r      <= hi_b_n;
            fb_r        <= fb_n;
            rd_r        <= rd_n;
            s_r         <= s_n;
            ctrl_r      <= ctrl_n;
            res_out_r   <= res_out_n;
            store_out_r <= store_out_n;
            rd_out_r    <= rd_out_n;
            ctrl_out_r  <= ctrl_out_n;
            nzcv_r      <= nzcv_n;
        end
    end

    assign alu_result_q    = res_out_r;
    assign store_data_q    = store_out_r;
    assign rd_q            = rd_out_r;
    assign rwrite_q        = ctrl_out_r.rwrite;
    assign we_q            = ctrl_out_r.we;
    assign data_input_on_q = ctrl_out_r.data_input_on;
    assign data_input_s_q  = ctrl_out_r.data_input_s;
    assign select_mem_q    = ctrl_out_r.select_mem;
    assign nzcv_q          = nzcv_r;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: reset, ALU ops, forwarding,
// multiplier timing, flush abort and back-to-back multiplies.
module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] data1, data2, imm_extend, inst;
    logic [3:0]  rd;
    logic        rwrite, we, data_input_on, data_input_s, opb_select, select_mem;
    logic [2:0]  alu_signal;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic [31:0] alu_result_q, store_data_q;
    logic [3:0]  rd_q;
    logic        rwrite_q, we_q, data_input_on_q, data_input_s_q, select_mem_q;
    logic [3:0]  nzcv_q;
    logic        stall_req;

    int tests;
    int failed;

    execute_stage dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .data1           (data1),
        .data2           (data2),
        .imm_extend      (imm_extend),
        .inst            (inst),
        .rd              (rd),
        .rwrite          (rwrite),
        .we              (we),
        .data_input_on   (data_input_on),
        .data_input_s    (data_input_s),
        .opb_select      (opb_select),
        .select_mem      (select_mem),
        .alu_signal      (alu_signal),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .mem_fwd_data    (mem_fwd_data),
        .wb_fwd_data     (wb_fwd_data),
        .alu_result_q    (alu_result_q),
        .store_data_q    (store_data_q),
        .rd_q            (rd_q),
        .rwrite_q        (rwrite_q),
        .we_q            (we_q),
        .data_input_on_q (data_input_on_q),
        .data_input_s_q  (data_input_s_q),
        .select_mem_q    (select_mem_q),
        .nzcv_q          (nzcv_q),
        .stall_req       (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 1'b0; data1 = 32'd0; data2 = 32'd0; imm_extend = 32'd0; inst = 32'd0;
        rd = 4'd0; rwrite = 1'b0; we = 1'b0; data_input_on = 1'b0; data_input_s = 1'b0;
        opb_select = 1'b0; select_mem = 1'b0; alu_signal = 3'b000;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        // Reset with every input high, LSL selected so no multiply is requested
        reset = 1'b1; flush = 1'b1;
        data1 = 32'hFFFF_FFFF; data2 = 32'hFFFF_FFFF; imm_extend = 32'hFFFF_FFFF;
        inst = 32'hFFFF_FFFF; rd = 4'hF; rwrite = 1'b1; we = 1'b1; data_input_on = 1'b1;
        data_input_s = 1'b1; opb_select = 1'b1; select_mem = 1'b1; alu_signal = 3'b110;
        fwd_a_sel = 2'b11; fwd_b_sel = 2'b11;
        mem_fwd_data = 32'hFFFF_FFFF; wb_fwd_data = 32'hFFFF_FFFF;
        tick();
        tick();
        check("rst_result", alu_result_q, 32'd0);
        check("rst_store", store_data_q, 32'd0);
        check("rst_rd", {28'd0, rd_q}, 32'd0);
        check("rst_ctrl", {27'd0, rwrite_q, we_q, data_input_on_q, data_input_s_q, select_mem_q}, 32'd0);
        check("rst_nzcv", {28'd0, nzcv_q}, 32'd0);
        reset = 1'b0; flush = 1'b0;
        #1;
        check("rst_stall", {31'd0, stall_req}, 32'd0);

        // ADD overflow into the sign bit
        clear_inputs();
        data1 = 32'h7FFF_FFFF; data2 = 32'd1; inst = 32'h0010_0000; rd = 4'd3;
        rwrite = 1'b1; data_input_on = 1'b1; alu_signal = 3'b000;
        tick();
        check("add_result", alu_result_q, 32'h8000_0000);
        check("add_nzcv", {28'd0, nzcv_q}, 32'h9);
        check("add_rd", {28'd0, rd_q}, 32'd3);
        check("add_ctrl", {27'd0, rwrite_q, we_q, data_input_on_q, data_input_s_q, select_mem_q}, 32'h14);
        check("add_store", store_data_q, 32'd1);

        // SUB with MEM-forwarded A and immediate B giving zero
        clear_inputs();
        data1 = 32'd99; data2 = 32'd7; fwd_a_sel = 2'b01; mem_fwd_data = 32'd5;
        opb_select = 1'b1; imm_extend = 32'd5; inst = 32'h0010_0000; alu_signal = 3'b001;
        tick();
        check("sub_result", alu_result_q, 32'd0);
        check("sub_nzcv", {28'd0, nzcv_q}, 32'h6);
        check("sub_store", store_data_q, 32'd7);

        // ORR without S keeps the flags
        clear_inputs();
        data1 = 32'h0000_00F0; data2 = 32'h0000_000F; we = 1'b1; alu_signal = 3'b011;
        tick();
        check("orr_result", alu_result_q, 32'h0000_00FF);
        check("orr_nzcv", {28'd0, nzcv_q}, 32'h6);
        check("orr_ctrl", {27'd0, rwrite_q, we_q, data_input_on_q, data_input_s_q, select_mem_q}, 32'h08);

        // MUL 0x00012345 * 0x100: three bubbles, result on the fourth edge
        clear_inputs();
        data1 = 32'h0001_2345; data2 = 32'h0000_0100; inst = 32'h0010_0000;
        rd = 4'd5; rwrite = 1'b1; alu_signal = 3'b111;
        #1;
        check("mul_stall0", {31'd0, stall_req}, 32'd1);
        tick();
        check("mul_bub1", {31'd0, rwrite_q}, 32'd0);
        check("mul_stall1", {31'd0, stall_req}, 32'd1);
        tick();
        check("mul_bub2", {31'd0, rwrite_q}, 32'd0);
        check("mul_stall2", {31'd0, stall_req}, 32'd1);
        tick();
        check("mul_bub3", {31'd0, rwrite_q}, 32'd0);
        check("mul_stall3", {31'd0, stall_req}, 32'd0);
        tick();
        check("mul_result", alu_result_q, 32'h0123_4500);
        check("mul_rd", {28'd0, rd_q}, 32'd5);
        check("mul_rwrite", {31'd0, rwrite_q}, 32'd1);
        check("mul_nzcv", {28'd0, nzcv_q}, 32'h2);

        // Back-to-back MUL, flushed in its second BUSY cycle
        data1 = 32'h0000_0010; data2 = 32'h0000_0202; rd = 4'd6;
        #1;
        check("mul2_stall_nogap", {31'd0, stall_req}, 32'd1);
        tick();
        check("mul2_bub1", {31'd0, rwrite_q}, 32'd0);
        tick();
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        tick();
        check("flush_bubble", {31'd0, rwrite_q}, 32'd0);
        check("flush_data_held", alu_result_q, 32'h0123_4500);
        check("flush_nzcv", {28'd0, nzcv_q}, 32'h2);

        // LSL with WB-forwarded B; a single-cycle result proves the FSM is IDLE
        clear_inputs();
        data1 = 32'd1; data2 = 32'd0; fwd_b_sel = 2'b10; wb_fwd_data = 32'h0000_0023;
        rd = 4'd7; rwrite = 1'b1; alu_signal = 3'b110;
        #1;
        check("lsl_stall", {31'd0, stall_req}, 32'd0);
        tick();
        check("lsl_result", alu_result_q, 32'h0000_0008);
        check("lsl_store", store_data_q, 32'h0000_0023);
        check("lsl_rd", {28'd0, rd_q}, 32'd7);

        // Flush with a MUL presented in IDLE must not start it
        clear_inputs();
        data1 = 32'd3; data2 = 32'd3; rwrite = 1'b1; alu_signal = 3'b111; flush = 1'b1;
        #1;
        check("fmul_stall", {31'd0, stall_req}, 32'd0);
        tick();
        check("fmul_bubble", {31'd0, rwrite_q}, 32'd0);
        clear_inputs();
        opb_select = 1'b1; imm_extend = 32'h0000_1234; inst = 32'h0010_0000;
        rwrite = 1'b1; alu_signal = 3'b101;
        #1;
        check("mov_stall", {31'd0, stall_req}, 32'd0);
        tick();
        check("mov_result", alu_result_q, 32'h0000_1234);
        check("mov_nzcv", {28'd0, nzcv_q}, 32'h2);
        check("mov_rwrite", {31'd0, rwrite_q}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
